// File: rtl/babysoc_pkg.sv
// Shared types and defaults for the babysoc DAC path.
// Holds the code type, pacer defaults and the slew helper.
package babysoc_pkg;

    localparam int DAC_W   = 10;
    localparam int DAC_MAX = (1 << DAC_W) - 1;

    typedef logic [DAC_W-1:0] dac_code_t;
    typedef logic [DAC_W:0]   dac_diff_t;

    localparam int DEF_DEPTH    = 8;
    localparam int DEF_DIV      = 16;
    localparam int DEF_MAX_STEP = 0;

    typedef enum logic {
        HOLD = 1'b0,
        SLEW = 1'b1
    } pacer_state_e;

    // One slew step from cur toward tgt; a zero step jumps straight there.
    function automatic dac_code_t step_toward(
        input dac_code_t cur,
        input dac_code_t tgt,
        input dac_diff_t max_step
    );
        dac_diff_t diff;
        dac_code_t nxt;
        if (tgt >= cur) begin
            diff = {1'b0, tgt} - {1'b0, cur};
        end else begin
            diff = {1'b0, cur} - {1'b0, tgt};
        end
        if (max_step == '0 || diff <= max_step) begin
            nxt = tgt;
        end else if (tgt > cur) begin
            nxt = cur + max_step[DAC_W-1:0];
        end else begin
            nxt = cur - max_step[DAC_W-1:0];
        end
        return nxt;
    endfunction

endpackage

// File: rtl/dac_sample_pacer_if.sv
// Bus between the rvmyth output side and the DAC pacer.
// master drives codes and flag clears; slave reports status.
interface dac_sample_pacer_if #(
    parameter int DEPTH = 8
);
    import babysoc_pkg::*;

    localparam int LW = $clog2(DEPTH) + 1;

    dac_code_t         core_out;
    logic              clr_flags;
    dac_code_t         dac_d;
    logic              sample_tick;
    logic [LW-1:0]     fifo_level;
    logic              overflow;
    logic              underflow;

    modport master (
        output core_out,
        output clr_flags,
        input  dac_d,
        input  sample_tick,
        input  fifo_level,
        input  overflow,
        input  underflow
    );

    modport slave (
        input  core_out,
        input  clr_flags,
        output dac_d,
        output sample_tick,
        output fifo_level,
        output overflow,
        output underflow
    );

endinterface

// File: rtl/pacer_fifo.sv
// Single-clock code FIFO with a separate up/down level counter.
// A push into a full FIFO with no pop is dropped and flagged on ovf_o.
module pacer_fifo
    import babysoc_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  dac_code_t     din_i,
    output dac_code_t     dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          ovf_o,
    output logic [LW-1:0] level_o
);

    dac_code_t     mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [LW-1:0] lvl_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (lvl_q == LW'(DEPTH));
    assign empty_o = (lvl_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign ovf_o   = push_i && full_o && !do_pop;
    assign dout_o  = mem_q[rd_q];
    assign level_o = lvl_q;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din_i;
        end
    end

    // Pointers wrap naturally; level tracks occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                lvl_q <= lvl_q + 1'b1;
            end else if (do_pop && !do_push) begin
                lvl_q <= lvl_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_sample_pacer.sv
// Paces rvmyth output codes onto the avsddac D input.
// Change-detect capture, fixed-rate ticks, optional slew, sticky flags.
module dac_sample_pacer
    import babysoc_pkg::*;
#(
    parameter int        DEPTH      = DEF_DEPTH,
    parameter int        DIV        = DEF_DIV,
    parameter int        MAX_STEP   = DEF_MAX_STEP,
    parameter dac_code_t RESET_CODE = '0
) (
    input logic               clk,
    input logic               reset,
    dac_sample_pacer_if.slave bus
);

    localparam int LW     = $clog2(DEPTH) + 1;
    localparam int CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int STEP_C = (MAX_STEP > DAC_MAX) ? DAC_MAX : MAX_STEP;
    localparam dac_diff_t STEP = dac_diff_t'(STEP_C);

    dac_code_t    prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    dac_code_t    code_q, code_d;
    dac_code_t    tgt_q, tgt_d;
    pacer_state_e state_q, state_d;
    logic         tick_q;
    logic         ovf_q, ovf_d;
    logic         unf_q, unf_d;

    logic          tick;
    logic          push;
    logic          pop;
    logic          unf_set;
    dac_code_t     fifo_dout;
    logic          fifo_empty;
    logic          fifo_full_unused;
    logic          fifo_ovf;
    logic [LW-1:0] level;

    assign push  = (bus.core_out != prev_q);
    assign tick  = (cnt_q == CW'(DIV - 1));
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    pacer_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (bus.core_out),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full_unused),
        .empty_o (fifo_empty),
        .ovf_o   (fifo_ovf),
        .level_o (level)
    );

    // Per-tick slew/pop decision and HOLD/SLEW next state.
    always_comb begin
        code_d  = code_q;
        tgt_d   = tgt_q;
        pop     = 1'b0;
        unf_set = 1'b0;
        if (tick) begin
            unique case (state_q)
                SLEW: begin
                    code_d = step_toward(code_q, tgt_q, STEP);
                end
                HOLD: begin
                    if (!fifo_empty) begin
                        pop    = 1'b1;
                        tgt_d  = fifo_dout;
                        code_d = step_toward(code_q, fifo_dout, STEP);
                    end else begin
                        unf_set = 1'b1;
                    end
                end
            endcase
        end
        state_d = (code_d == tgt_d) ? HOLD : SLEW;
    end

    // Sticky flags: a set in the same cycle as a clear wins.
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (bus.clr_flags) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (fifo_ovf) begin
            ovf_d = 1'b1;
        end
        if (unf_set) begin
            unf_d = 1'b1;
        end
    end

    // State registers; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= RESET_CODE;
            cnt_q   <= '0;
            code_q  <= RESET_CODE;
            tgt_q   <= RESET_CODE;
            state_q <= HOLD;
            tick_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            prev_q  <= bus.core_out;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            tgt_q   <= tgt_d;
            state_q <= state_d;
            tick_q  <= tick;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.dac_d       = code_q;
    assign bus.sample_tick = tick_q;
    assign bus.fifo_level  = level;
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = unf_q;

endmodule

// File: tb/tb_dac_sample_pacer.sv
// Scoreboard bench for dac_sample_pacer across four parameter sets.
// Expected DAC codes are queued at stimulus time and popped by a monitor.
module tb_dac_sample_pacer;
    import babysoc_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] rst_v = 4'hF;

    int n_vec = 0;
    int n_err = 0;

    dac_sample_pacer_if #(.DEPTH(8)) if_a ();
    dac_sample_pacer_if #(.DEPTH(8)) if_b ();
    dac_sample_pacer_if #(.DEPTH(8)) if_c ();
    dac_sample_pacer_if #(.DEPTH(8)) if_d ();

    dac_sample_pacer #(
        .DEPTH(8), .DIV(4), .MAX_STEP(0), .RESET_CODE(10'd0)
    ) u_a (
        .clk(clk), .reset(rst_v[0]), .bus(if_a)
    );

    dac_sample_pacer #(
        .DEPTH(8), .DIV(1), .MAX_STEP(0), .RESET_CODE(10'd0)
    ) u_b (
        .clk(clk), .reset(rst_v[1]), .bus(if_b)
    );

    dac_sample_pacer #(
        .DEPTH(8), .DIV(100), .MAX_STEP(0), .RESET_CODE(10'd0)
    ) u_c (
        .clk(clk), .reset(rst_v[2]), .bus(if_c)
    );

    dac_sample_pacer #(
        .DEPTH(8), .DIV(2), .MAX_STEP(16), .RESET_CODE(10'd0)
    ) u_d (
        .clk(clk), .reset(rst_v[3]), .bus(if_d)
    );

    dac_code_t dac_w [4];
    logic      tk_w  [4];
    assign dac_w[0] = if_a.dac_d;
    assign dac_w[1] = if_b.dac_d;
    assign dac_w[2] = if_c.dac_d;
    assign dac_w[3] = if_d.dac_d;
    assign tk_w[0]  = if_a.sample_tick;
    assign tk_w[1]  = if_b.sample_tick;
    assign tk_w[2]  = if_c.sample_tick;
    assign tk_w[3]  = if_d.sample_tick;

    dac_code_t q_a [$];
    dac_code_t q_b [$];
    dac_code_t q_c [$];
    dac_code_t q_d [$];

    task automatic exp_push(input int i, input dac_code_t v);
        case (i)
            0: q_a.push_back(v);
            1: q_b.push_back(v);
            2: q_c.push_back(v);
            default: q_d.push_back(v);
        endcase
    endtask

    task automatic exp_pop(input int i, output bit ok,
                           output dac_code_t v);
        ok = 1'b1;
        v  = '0;
        case (i)
            0: if (q_a.size() > 0) v = q_a.pop_front(); else ok = 1'b0;
            1: if (q_b.size() > 0) v = q_b.pop_front(); else ok = 1'b0;
            2: if (q_c.size() > 0) v = q_c.pop_front(); else ok = 1'b0;
            default:
               if (q_d.size() > 0) v = q_d.pop_front(); else ok = 1'b0;
        endcase
    endtask

    function automatic int exp_left(input int i);
        case (i)
            0: return q_a.size();
            1: return q_b.size();
            2: return q_c.size();
            default: return q_d.size();
        endcase
    endfunction

    task automatic chk(input string nm, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, got, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every tick that moves dac_d must match the next queued code.
    dac_code_t last_v [4];
    dac_code_t mon_v;
    bit        mon_ok;
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst_v[i]) begin
                last_v[i] = '0;
            end else if (tk_w[i] && dac_w[i] != last_v[i]) begin
                last_v[i] = dac_w[i];
                exp_pop(i, mon_ok, mon_v);
                if (!mon_ok) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb[%0d] unexpected: got 0x%0h, want none",
                             i, dac_w[i]);
                end else begin
                    chk($sformatf("sb[%0d] order", i), dac_w[i], mon_v);
                end
            end
        end
    end

    initial begin
        dac_code_t c;
        if_a.core_out = '0; if_a.clr_flags = 1'b0;
        if_b.core_out = '0; if_b.clr_flags = 1'b0;
        if_c.core_out = '0; if_c.clr_flags = 1'b0;
        if_d.core_out = '0; if_d.clr_flags = 1'b0;
        cyc(3);

        // Basic capture, first tick, underflow and clear (DIV=4).
        rst_v[0] = 1'b0;
        chk("a reset dac", if_a.dac_d, 0);
        chk("a reset level", if_a.fifo_level, 0);
        chk("a reset tick", if_a.sample_tick, 0);
        cyc(1);
        if_a.core_out = 10'h155;
        exp_push(0, 10'h155);
        cyc(1);
        chk("a level after push", if_a.fifo_level, 1);
        cyc(2);
        chk("a dac first tick", if_a.dac_d, 10'h155);
        chk("a tick pulse", if_a.sample_tick, 1);
        chk("a level after pop", if_a.fifo_level, 0);
        chk("a no underflow", if_a.underflow, 0);
        cyc(4);
        chk("a underflow empty tick", if_a.underflow, 1);
        if_a.clr_flags = 1'b1;
        cyc(1);
        if_a.clr_flags = 1'b0;
        chk("a underflow cleared", if_a.underflow, 0);
        cyc(3);
        chk("a underflow again", if_a.underflow, 1);

        // Full FIFO with a pop and a push on the same tick edge.
        if_a.core_out = '0;
        rst_v[0] = 1'b1;
        cyc(2);
        rst_v[0] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            c = dac_code_t'(10'h200 + k);
            if_a.core_out = c;
            exp_push(0, c);
            cyc(1);
        end
        chk("a full level", if_a.fifo_level, 8);
        chk("a full no ovf", if_a.overflow, 0);
        cyc(1);
        chk("a full hold level", if_a.fifo_level, 8);
        if_a.core_out = 10'h20B;
        exp_push(0, 10'h20B);
        cyc(1);
        chk("a full+tick level", if_a.fifo_level, 8);
        chk("a full+tick ovf", if_a.overflow, 0);
        chk("a full+tick unf", if_a.underflow, 0);
        cyc(40);
        chk("a drained level", if_a.fifo_level, 0);

        // DIV=1: pops keep pace with a push every cycle.
        rst_v[1] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            c = dac_code_t'(10'h100 + 7 * k);
            if_b.core_out = c;
            exp_push(1, c);
            cyc(1);
            if (k == 1) begin
                chk("b level first", if_b.fifo_level, 1);
                chk("b empty-pop underflow", if_b.underflow, 1);
            end
        end
        cyc(2);
        chk("b level end", if_b.fifo_level, 0);
        chk("b no overflow", if_b.overflow, 0);

        // DIV=100: nine pushes into eight entries drop the last.
        rst_v[2] = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            c = dac_code_t'(10'h300 + k);
            if_c.core_out = c;
            if (k <= 8) exp_push(2, c);
            cyc(1);
        end
        chk("c level full", if_c.fifo_level, 8);
        chk("c overflow set", if_c.overflow, 1);
        if_c.clr_flags = 1'b1;
        cyc(1);
        if_c.clr_flags = 1'b0;
        chk("c overflow cleared", if_c.overflow, 0);
        cyc(800);
        chk("c drained level", if_c.fifo_level, 0);
        chk("c overflow stays 0", if_c.overflow, 0);

        // Slew limit 16, DIV=2, then reset mid-slew.
        rst_v[3] = 1'b0;
        cyc(1);
        if_d.core_out = 10'h040;
        exp_push(3, 10'h010);
        exp_push(3, 10'h020);
        exp_push(3, 10'h030);
        exp_push(3, 10'h040);
        cyc(3);
        chk("d first step", if_d.dac_d, 10'h010);
        if_d.core_out = 10'h038;
        exp_push(3, 10'h038);
        cyc(5);
        chk("d mid slew dac", if_d.dac_d, 10'h030);
        chk("d no pop while slewing", if_d.fifo_level, 1);
        cyc(1);
        chk("d reached target", if_d.dac_d, 10'h040);
        chk("d still queued", if_d.fifo_level, 1);
        cyc(2);
        chk("d down step exact", if_d.dac_d, 10'h038);
        chk("d popped", if_d.fifo_level, 0);
        if_d.core_out = 10'h3FF;
        exp_push(3, 10'h048);
        exp_push(3, 10'h058);
        cyc(2);
        chk("d big step", if_d.dac_d, 10'h048);
        if_d.core_out = 10'h100;
        cyc(1);
        if_d.core_out = 10'h101;
        cyc(1);
        if_d.core_out = 10'h102;
        cyc(1);
        chk("d three queued", if_d.fifo_level, 3);
        rst_v[3] = 1'b1;
        cyc(1);
        chk("d rst dac", if_d.dac_d, 0);
        chk("d rst level", if_d.fifo_level, 0);
        chk("d rst ovf", if_d.overflow, 0);
        chk("d rst unf", if_d.underflow, 0);
        chk("d rst tick", if_d.sample_tick, 0);
        if_d.core_out = '0;
        rst_v[3] = 1'b0;
        cyc(1);
        chk("d cnt restart no tick", if_d.sample_tick, 0);
        cyc(1);
        chk("d cnt restart tick", if_d.sample_tick, 1);
        cyc(4);

        for (int i = 0; i < 4; i++) begin
            chk($sformatf("sb[%0d] leftover", i), exp_left(i), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
